// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared command/condition codes, flag indices and FSM states for alu_issue_ctrl.
package alu_ctrl_pkg;
  localparam logic [3:0] CMD_AND = 4'd0;
  localparam logic [3:0] CMD_XOR = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_RSB = 4'd3;
  localparam logic [3:0] CMD_ADD = 4'd4;
  localparam logic [3:0] CMD_CMP = 4'd10;
  localparam logic [3:0] CMD_ORR = 4'd12;
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;
  localparam int F_N = 3;
  localparam int F_Z = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;
  function automatic logic cmd_legal(input logic [3:0] c);
    return c inside {CMD_AND, CMD_XOR, CMD_SUB, CMD_RSB, CMD_ADD, CMD_CMP, CMD_ORR};
  endfunction
endpackage

// File: rtl/alu_cond_eval.sv
// alu_cond_eval: ARM condition check of cond against NZCV flags.
module alu_cond_eval
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v;
  logic [7:0] base;
  assign {n, z, c, v} = {flags[F_N], flags[F_Z], flags[F_C], flags[F_V]};
  // Odd codes are the negation of the even code below them; 14/15 fall out as AL/NV.
  assign base = {1'b1, !z && (n == v), n == v, c && !z, v, n, c, z};
  assign pass = base[cond[3:1]] ^ cond[0];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues conditional ops to the ALU, owns NZCV, returns results.
// Optional ALU_CTRL_SKIP_CNT_EN builds the saturating condition-fail counter.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_cmd,
  input  logic              in_s,
  input  logic [3:0]        in_rd,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_cmd,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_flags,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [3:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        flags_q,
  output logic              illegal,
  output logic [15:0]       skip_cnt
);
  state_e state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, wb_data_q, wb_data_d;
  logic [3:0] cmd_q, cmd_d, rd_q, rd_d, flags_d;
  logic s_q, s_d, illegal_q, illegal_d, pass, take;

  alu_cond_eval u_cond (.cond(in_cond), .flags(flags_q), .pass(pass));

  assign take = in_valid && state_q == S_IDLE;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cmd_d     = cmd_q;
    s_d       = s_q;
    rd_d      = rd_q;
    wb_data_d = wb_data_q;
    flags_d   = flags_q;
    illegal_d = take && !cmd_legal(in_cmd);
    if (take && cmd_legal(in_cmd) && pass) begin
      state_d = S_EXEC;
      a_d     = in_a;
      b_d     = in_b;
      cmd_d   = in_cmd;
      s_d     = in_s;
      rd_d    = in_rd;
    end
    if (state_q == S_EXEC) begin
      wb_data_d = alu_out;
      flags_d   = (s_q || cmd_q == CMD_CMP) ? alu_flags : flags_q;
      state_d   = cmd_q == CMD_CMP ? S_IDLE : S_WB;
    end
    if (state_q == S_WB && wb_ready) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cmd_q     <= '0;
      s_q       <= 1'b0;
      rd_q      <= '0;
      wb_data_q <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cmd_q     <= cmd_d;
      s_q       <= s_d;
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready = state_q == S_IDLE;
  assign wb_valid = state_q == S_WB;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_cmd  = cmd_q;
  assign wb_rd    = rd_q;
  assign wb_data  = wb_data_q;
  assign illegal  = illegal_q;

`ifdef ALU_CTRL_SKIP_CNT_EN
  logic [15:0] skip_q, skip_d;
  logic skip_inc;
  assign skip_inc = take && cmd_legal(in_cmd) && !pass;
  always_comb skip_d = (skip_inc && skip_q != 16'hFFFF) ? skip_q + 16'd1 : skip_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) skip_q <= '0;
    else skip_q <= skip_d;
  end
  assign skip_cnt = skip_q;
`else
  assign skip_cnt = '0;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed + random checks of alu_issue_ctrl against a behavioural model.
module tb_alu_issue_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, in_s = 1'b0, wb_valid, wb_ready = 1'b0, illegal;
  logic [3:0] in_cond = '0, in_cmd = '0, in_rd = '0, alu_cmd, alu_flags, wb_rd, flags_q;
  logic [31:0] in_a = '0, in_b = '0, alu_a, alu_b, alu_out, wb_data;
  logic [15:0] skip_cnt;
  int total = 0, bad = 0;
  logic [3:0] mflags = '0;
  logic [15:0] mskip = '0;

  alu_issue_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_cond(in_cond), .in_cmd(in_cmd), .in_s(in_s), .in_rd(in_rd),
    .in_a(in_a), .in_b(in_b), .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .alu_out(alu_out), .alu_flags(alu_flags), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .flags_q(flags_q),
    .illegal(illegal), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {N,Z,C,V,out}
  function automatic logic [35:0] alu_ref(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    logic v;
    v = 1'b0;
    case (cmd)
      4'd0:  r = {1'b0, a & b};
      4'd1:  r = {1'b0, a ^ b};
      4'd12: r = {1'b0, a | b};
      4'd4: begin r = {1'b0, a} + {1'b0, b}; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd3: begin r = {1'b0, b} + {1'b0, ~a} + 33'd1; v = (a[31] != b[31]) && (r[31] != b[31]); end
      4'd2, 4'd10: begin r = {1'b0, a} + {1'b0, ~b} + 33'd1; v = (a[31] != b[31]) && (r[31] != a[31]); end
      default: r = '0;
    endcase
    return {r[31], r[31:0] == 32'd0, r[32], v, r[31:0]};
  endfunction

  function automatic logic cond_ref(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      0: return z;          1: return !z;
      2: return c;          3: return !c;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return c && !z;    9: return !c || z;
      10: return n == v;    11: return n != v;
      12: return !z && n == v;
      13: return z || n != v;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb {alu_flags, alu_out} = alu_ref(alu_cmd, alu_a, alu_b);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [3:0] cond, input logic [3:0] cmd, input logic s,
                    input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b, input int stall);
    logic [35:0] r;
    logic legal, pass;
    legal = cmd inside {0, 1, 2, 3, 4, 10, 12};
    pass = cond_ref(cond, mflags);
    r = alu_ref(cmd, a, b);
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    {in_valid, in_cond, in_cmd, in_s, in_rd, in_a, in_b} = {1'b1, cond, cmd, s, rd, a, b};
    @(negedge clk);
    in_valid = 1'b0;
    if (!legal) begin
      chk("illegal_pulse", illegal, 1);
      chk("illegal_flags", flags_q, mflags);
      chk("illegal_skip", skip_cnt, mskip);
      chk("illegal_ready", in_ready, 1);
      @(negedge clk);
      chk("illegal_once", illegal, 0);
    end else if (!pass) begin
`ifdef ALU_CTRL_SKIP_CNT_EN
      if (mskip != 16'hFFFF) mskip++;
`endif
      chk("skip_cnt", skip_cnt, mskip);
      chk("skip_ready", in_ready, 1);
      chk("skip_illegal", illegal, 0);
    end else begin
      chk("exec_a", alu_a, a);
      chk("exec_b", alu_b, b);
      chk("exec_cmd", alu_cmd, cmd);
      chk("exec_busy", {in_ready, wb_valid}, 2'b00);
      if (s || cmd == 4'd10) mflags = r[35:32];
      @(negedge clk);
      chk("flags", flags_q, mflags);
      if (cmd == 4'd10) begin
        chk("cmp_nowb", wb_valid, 0);
        chk("cmp_ready", in_ready, 1);
      end else begin
        chk("wb_valid", wb_valid, 1);
        chk("wb_data", wb_data, r[31:0]);
        chk("wb_rd", wb_rd, rd);
        for (int i = 0; i < stall; i++) begin
          @(negedge clk);
          chk("stall_hold", {wb_valid, in_ready, wb_rd, wb_data}, {2'b10, rd, r[31:0]});
        end
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        chk("wb_done", {wb_valid, in_ready}, 2'b01);
      end
    end
  endtask

  initial begin
    logic [3:0] lc [7] = '{0, 1, 2, 3, 4, 10, 12};
    logic [3:0] cmd;
    int n_nv;
    #12;
    chk("rst_outs", {flags_q, wb_valid, wb_data, wb_rd, alu_a, alu_b, alu_cmd, illegal, skip_cnt}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    op(4'd14, 4'd4, 1'b1, 4'd3, 32'h7FFF_FFFF, 32'd1, 0);
    chk("add_result", wb_data, 32'h8000_0000);
    chk("add_nv", flags_q, 4'b1001);
    op(4'd14, 4'd10, 1'b0, 4'd1, 32'd5, 32'd5, 0);
    chk("cmp_z", flags_q[2], 1);
    op(4'd1, 4'd2, 1'b1, 4'd2, 32'd9, 32'd4, 0);
    op(4'd0, 4'd2, 1'b0, 4'd2, 32'd9, 32'd4, 0);
    chk("sub_eq_data", wb_data, 32'd5);
    op(4'd14, 4'd12, 1'b0, 4'd7, 32'hF0F0_0000, 32'h0000_0F0F, 4);
    op(4'd14, 4'd7, 1'b1, 4'd5, 32'd1, 32'd2, 0);
    op(4'd14, 4'd1, 1'b0, 4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("xor_noflags", flags_q, 4'b0110);
    // Reset while the next operation is in EXEC
    @(negedge clk);
    {in_valid, in_cond, in_cmd, in_s, in_rd, in_a, in_b} = {1'b1, 4'd14, 4'd4, 1'b1, 4'd9, 32'd3, 32'd4};
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_exec", alu_a, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {flags_q, wb_valid, wb_data, wb_rd, alu_a, alu_b, alu_cmd, illegal, skip_cnt}, '0);
    mflags = '0;
    mskip = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {wb_valid, in_ready, flags_q}, {2'b01, 4'b0000});
    end
    for (int i = 0; i < 150; i++) begin
      cmd = ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : lc[$urandom_range(6)];
      op(4'($urandom_range(15)), cmd, 1'($urandom), 4'($urandom), $urandom, $urandom, $urandom_range(2));
    end
`ifdef ALU_CTRL_SKIP_CNT_EN
    n_nv = 65537;
`else
    n_nv = 20;
`endif
    @(negedge clk);
    {in_valid, in_cond, in_cmd} = {1'b1, 4'd15, 4'd4};
    for (int i = 0; i < n_nv; i++) @(negedge clk);
    in_valid = 1'b0;
`ifdef ALU_CTRL_SKIP_CNT_EN
    mskip = 16'hFFFF;
`endif
    chk("nv_skip_sat", skip_cnt, mskip);
    chk("nv_ready", {in_ready, wb_valid}, 2'b10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential issue/condition controller that sits in front of the 32-bit combinational ALU. It accepts one decoded data-processing operation at a time over a valid/ready handshake and evaluates its ARM-style condition field against a registered NZCV flag register. It drives the ALU's `A`/`B`/`cmd` inputs, captures `out`/`flags`, updates the flag register, and returns the result over a second valid/ready handshake.

## Interface
- `DATA_W`, default 32: operand and result width; the ALU is 32-bit, so only 32 is supported.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  controller can accept; high only in IDLE.
- `in_cond`  in  4  condition code.
- `in_cmd`  in  4  ALU command.
- `in_s`  in  1  set-flags request.
- `in_rd`  in  4  destination tag.
- `in_a`, `in_b`  in  DATA_W each  operands.
- `alu_a`, `alu_b`  out  DATA_W each  to ALU `A`/`B`.
- `alu_cmd`  out  4  to ALU `cmd`.
- `alu_out`  in  DATA_W  from ALU `out`.
- `alu_flags`  in  4  from ALU `flags`, ordered {N,Z,C,V}.
- `wb_valid`  out  1  result available.
- `wb_ready`  in  1  consumer takes result.
- `wb_rd`  out  4  destination tag of the result.
- `wb_data`  out  DATA_W  result.
- `flags_q`  out  4  architectural NZCV, ordered {N,Z,C,V}.
- `illegal`  out  1  one-cycle pulse when an unsupported command is accepted.
- `skip_cnt`  out  16  count of condition-failed operations (see Configuration).

## Operation
- Supported commands: 0 AND, 1 XOR, 2 SUB, 3 RSB, 4 ADD, 10 CMP, 12 OR. Any other value is illegal.
- FSM has three states: IDLE, EXEC, WB.
- **IDLE**
  - A handshake occurs when `in_valid && in_ready`.
  - On the handshake, latch cmd, s, rd, a and b, and evaluate `in_cond` against the current `flags_q`.
  - Condition fails: drop the operation, stay in IDLE, increment `skip_cnt`.
  - Command illegal: drop the operation, pulse `illegal`, stay in IDLE. Illegal has priority over condition fail, and the skip counter is not incremented.
  - Otherwise: go to EXEC.
- **Condition codes**
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V).
  - 14 AL always passes; 15 NV never passes.
- **EXEC** (exactly one cycle)
  - Drive the `alu_*` ports from the latched operation.
  - At the end of the cycle, capture `alu_out` into `wb_data`.
  - Load `flags_q <= alu_flags` if the latched s is 1 or cmd is 10.
  - cmd 10 (CMP) goes back to IDLE with no writeback. Every other command goes to WB.
- **WB**
  - `wb_valid` is high; `wb_data` and `wb_rd` are held stable until `wb_ready`.
  - On `wb_valid && wb_ready`, return to IDLE.
- `alu_*` outputs hold their last values outside EXEC; they are not zeroed.
- **Reset (asynchronous, any state including mid-EXEC or mid-WB)**
  - State goes to IDLE and the in-flight operation is discarded with no flag update.
  - `flags_q`=0, `wb_valid`=0, `wb_data`=0, `wb_rd`=0.
  - `alu_a`=0, `alu_b`=0, `alu_cmd`=0, `illegal`=0, `skip_cnt`=0.
  - `in_ready`=1 immediately after reset is released.

## Timing
- Accept in cycle 0, EXEC in cycle 1, `wb_valid` first high in cycle 2. New `flags_q` is visible from cycle 2.
- Minimum throughput:
  - 3 cycles per written-back operation when `wb_ready` is tied high.
  - 2 cycles per CMP.
  - 1 cycle per skipped or illegal operation.
- `in_ready` is a registered function of state (IDLE only) and has no combinational path from `wb_ready`.
- The condition for operation N+1 always sees the flags written by operation N; no hazard exists because acceptance happens only in IDLE.
- `illegal` is high in the cycle after the accepting edge, for one cycle.

## Configuration
- `ALU_CTRL_SKIP_CNT_EN`
  - Defined: `skip_cnt` is a 16-bit counter that increments once per condition-failed handshake and saturates at 0xFFFF.
  - Undefined: the counter logic is not built and `skip_cnt` is tied to 0. The port list is unchanged.

## Structure
- Package `alu_ctrl_pkg` holds:
  - command constants (AND=0, XOR=1, SUB=2, RSB=3, ADD=4, CMP=10, ORR=12);
  - condition-code constants 0–15;
  - flag bit indices N=3, Z=2, C=1, V=0;
  - the FSM state enum.
- Sub-module `alu_cond_eval` is combinational: cond[3:0] and flags[3:0] in, pass out. It is instantiated once.

## Test plan
- Reset, then ADD with cond AL, s=1, a=0x7FFFFFFF, b=1 -> `wb_data`=0x80000000, `wb_valid` in cycle 2, `flags_q` N=1, V=1.
- CMP a=5, b=5 -> no `wb_valid`, `flags_q` Z=1. Then SUB cond NE -> dropped and `skip_cnt`=1; SUB cond EQ -> executes.
- WB with `wb_ready` low for 4 cycles -> `wb_data`/`wb_rd` stable, `in_ready`=0 throughout, return to IDLE on the cycle `wb_ready` rises.
- cmd=7 -> `illegal` single pulse, `flags_q` unchanged, `skip_cnt` unchanged, `in_ready` high next cycle.
- XOR with s=0 -> `flags_q` unchanged. Assert `rst_n` low during EXEC -> all outputs 0 asynchronously, no writeback after release.
- With the macro defined, 65537 NV operations -> `skip_cnt`=0xFFFF. With it undefined -> `skip_cnt` always 0.
